data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (rst==0 at a rising clk edge resets the block).
REQ-005 SHALL have port req_valid  input  1  load/store request from the CPU MEM stage.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port terminate  input  1  program-end request; starts memory dump.
REQ-010 SHALL have port req_ready  output  1  request accepted this cycle when req_valid & req_ready.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  load data; valid only while rsp_valid.
REQ-013 SHALL have port addr_err  output  1  valid only with rsp_valid; misaligned or out-of-range address.
REQ-014 SHALL have port busy  output  1  pipeline stall request.
REQ-015 SHALL have port dump_valid  output  1  dump word present this cycle.
REQ-016 SHALL have port dump_addr  output  32  word index of dump word.
REQ-017 SHALL have port dump_data  output  32  dump word contents.
REQ-018 SHALL have port dump_done  output  1  sticky; dump complete.

Function
REQ-019 SHALL implement states IDLE, WAIT, RESP, DUMP, DONE.
REQ-020 SHALL drive req_ready=1 only in IDLE with terminate==0; 0 in all other states.
REQ-021 SHALL, on acceptance in IDLE, latch we/addr/wdata and enter WAIT if WAIT_CYCLES>0, else RESP.
REQ-022 SHALL stay in WAIT exactly WAIT_CYCLES cycles (down-counter loaded at acceptance), then enter RESP.
REQ-023 SHALL assert rsp_valid for exactly the one RESP cycle; accept at cycle T -> rsp_valid at T+1+WAIT_CYCLES.
REQ-024 SHALL return to IDLE after RESP; back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-025 SHALL use word index req_addr[31:2]; addr_err=1 if req_addr[1:0]!=0 or index>=DEPTH.
REQ-026 SHALL, on a store without error, write the array on the RESP-entry edge; rsp_rdata=0 for stores.
REQ-027 SHALL, on a load, drive rsp_rdata with the array word read at RESP (includes any store completed earlier).
REQ-028 SHALL, on addr_err, perform no write and drive rsp_rdata=0.
REQ-029 SHALL drive busy=1 in WAIT, DUMP, DONE; 0 in IDLE and RESP.
REQ-030 SHALL sample terminate in IDLE only; terminate in WAIT/RESP is held pending (latched) and taken on return to IDLE.
REQ-031 SHALL give terminate priority over a simultaneous req_valid in IDLE (request not accepted).
REQ-032 SHALL in DUMP output one word per cycle, dump_addr 0..DEPTH-1 ascending, dump_valid=1, dump_data=array[dump_addr].
REQ-033 SHALL enter DONE after the word DEPTH-1 is output; DONE holds dump_done=1, dump_valid=0, and ignores all inputs until reset.
REQ-034 SHALL keep dump_valid=0 and dump_addr=0 outside DUMP.

Reset
REQ-035 SHALL on reset force IDLE, clear the wait counter and pending-terminate flag, and drive rsp_valid=0, addr_err=0, rsp_rdata=0, busy=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0 (req_ready=1 once reset is released).
REQ-036 SHALL not clear the data array on reset; contents survive reset.
REQ-037 SHALL abort any in-flight transaction (no write, no response) and any dump in progress when reset occurs.

Verification
REQ-038 Store 0xDEADBEEF to 0x10, then load 0x10, WAIT_CYCLES=2 -> each rsp_valid exactly 3 cycles after acceptance; load rsp_rdata=0xDEADBEEF, addr_err=0.
REQ-039 WAIT_CYCLES=0, continuous req_valid loads -> req_ready pattern 1,0 repeating; rsp_valid one cycle after each acceptance.
REQ-040 Load 0x12 and store to 0x400 (DEPTH=256) -> addr_err=1, rsp_rdata=0, array word 0 unchanged.
REQ-041 terminate raised during WAIT of a store to 0x8 -> store completes with rsp_valid, then DUMP begins; dump_addr=2 shows the stored value; dump_done=1 after DEPTH dump cycles.
REQ-042 terminate and req_valid in same IDLE cycle -> req_ready=0, no response, DUMP starts next cycle.
REQ-043 rst=0 for one cycle during DUMP at dump_addr=5 -> all outputs return to reset values next cycle; a load to a previously written address still returns the stored data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder for the CPU MEM stage: fixed-latency
// load/store handshake with wait states, plus a full memory dump on program end.
module data_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        terminate,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        addr_err,
   output logic        busy,
   output logic        dump_valid,
   output logic [31:0] dump_addr,
   output logic [31:0] dump_data,
   output logic        dump_done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_DUMP,
      ST_DONE
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [31:0]     r_mem [DEPTH];
   logic [3:0]      r_waitCnt;
   logic            r_termPend;
   logic            r_we;
   logic            r_err;
   logic [AW-1:0]   r_idx;
   logic [31:0]     r_wdata;
   logic [AW-1:0]   r_dumpAddr;

   logic            w_accept;
   logic            w_termReq;
   logic            w_reqErr;
   logic [AW-1:0]   w_reqIdx;
   logic            w_wrEn;
   logic [AW-1:0]   w_wrIdx;
   logic [31:0]     w_wrData;
   logic            w_wrWe;
   logic            w_wrErr;

   assign w_reqIdx  = req_addr[AW+1:2];
   assign w_reqErr  = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
   assign w_termReq = terminate | r_termPend;
   assign w_accept  = req_valid & req_ready;

   // The store lands on the edge that enters RESP; with no wait states that is
   // the acceptance edge itself, so the request fields come straight from the ports.
   assign w_wrWe   = (r_state == ST_IDLE) ? req_we    : r_we;
   assign w_wrErr  = (r_state == ST_IDLE) ? w_reqErr  : r_err;
   assign w_wrIdx  = (r_state == ST_IDLE) ? w_reqIdx  : r_idx;
   assign w_wrData = (r_state == ST_IDLE) ? req_wdata : r_wdata;
   assign w_wrEn   = rst & (w_nextState == ST_RESP) & w_wrWe & ~w_wrErr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_termReq) begin
               w_nextState = ST_DUMP;
            end else if (req_valid) begin
               w_nextState = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_waitCnt == 4'd1) begin
               w_nextState = ST_RESP;
            end
         end
         ST_RESP: w_nextState = ST_IDLE;
         ST_DUMP: begin
            if (r_dumpAddr == AW'(DEPTH - 1)) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: w_nextState = ST_DONE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (r_state == ST_IDLE) & ~w_termReq;
      rsp_valid  = (r_state == ST_RESP);
      addr_err   = (r_state == ST_RESP) & r_err;
      rsp_rdata  = 32'd0;
      if ((r_state == ST_RESP) && !r_we && !r_err) begin
         rsp_rdata = r_mem[r_idx];
      end
      busy       = (r_state == ST_WAIT) || (r_state == ST_DUMP) || (r_state == ST_DONE);
      dump_valid = (r_state == ST_DUMP);
      dump_addr  = 32'd0;
      dump_data  = 32'd0;
      if (r_state == ST_DUMP) begin
         dump_addr = 32'(r_dumpAddr);
         dump_data = r_mem[r_dumpAddr];
      end
      dump_done  = (r_state == ST_DONE);
   end

   // Terminate arriving mid-transaction is remembered until the block is idle again.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_waitCnt  <= 4'd0;
         r_termPend <= 1'b0;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= 32'd0;
         r_dumpAddr <= '0;
      end else begin
         if (w_accept) begin
            r_we      <= req_we;
            r_err     <= w_reqErr;
            r_idx     <= w_reqIdx;
            r_wdata   <= req_wdata;
            r_waitCnt <= 4'(WAIT_CYCLES);
         end else if (r_state == ST_WAIT) begin
            r_waitCnt <= r_waitCnt - 4'd1;
         end
         if (((r_state == ST_WAIT) || (r_state == ST_RESP)) && terminate) begin
            r_termPend <= 1'b1;
         end else if (r_state == ST_IDLE) begin
            r_termPend <= 1'b0;
         end
         if (r_state == ST_DUMP) begin
            r_dumpAddr <= r_dumpAddr + 1'b1;
         end else begin
            r_dumpAddr <= '0;
         end
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_mem[w_wrIdx] <= w_wrData;
      end
   end

endmodule
